// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle for the bit-serial adder: start/busy/done framing plus operands and result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles; result WIDTH cycles after start.
// No backpressure: start is sampled only in IDLE and ignored while busy or done.
module adder_logic_1_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic c_out,
    output logic sum
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_s_q, sh_s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cell_sum, cell_cout;

    adder_logic_1_bit u_cell (
        .a     (sh_a_q[0]),
        .b     (sh_b_q[0]),
        .c_in  (carry_q),
        .c_out (cell_cout),
        .sum   (cell_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_s_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_s_q  <= sh_s_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_s_d  = sh_s_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_a_d  = bus.a;
                    sh_b_d  = bus.b;
                    sh_s_d  = '0;
                    carry_d = bus.c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB.
                sh_s_d  = (sh_s_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));
                carry_d = cell_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = sh_s_d;
                    cout_d  = cell_cout;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH 8, 4 and 1 with a per-instance result scoreboard.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
    serial_adder_ctrl_if #(.WIDTH(4)) if4 ();
    serial_adder_ctrl_if #(.WIDTH(1)) if1 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [1:0] q1[$];
    logic [8:0] last8 = '0;
    logic [4:0] last4 = '0;
    logic [1:0] last1 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result scoreboards: pop on each done pulse, otherwise the held result must match the last expected.
    always @(negedge clk) begin
        if (!rst_n) last8 = '0;
        else if (if8.done) begin
            chk("w8_done_not_busy", if8.busy, 0);
            chk("w8_done_expected", q8.size() != 0, 1);
            if (q8.size() != 0) begin
                last8 = q8.pop_front();
                chk("w8_result", {if8.c_out, if8.sum}, last8);
            end
        end else chk("w8_hold", {if8.c_out, if8.sum}, last8);
    end

    always @(negedge clk) begin
        if (!rst_n) last4 = '0;
        else if (if4.done) begin
            chk("w4_done_not_busy", if4.busy, 0);
            chk("w4_done_expected", q4.size() != 0, 1);
            if (q4.size() != 0) begin
                last4 = q4.pop_front();
                chk("w4_result", {if4.c_out, if4.sum}, last4);
            end
        end else chk("w4_hold", {if4.c_out, if4.sum}, last4);
    end

    always @(negedge clk) begin
        if (!rst_n) last1 = '0;
        else if (if1.done) begin
            chk("w1_done_not_busy", if1.busy, 0);
            chk("w1_done_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                last1 = q1.pop_front();
                chk("w1_result", {if1.c_out, if1.sum}, last1);
            end
        end else chk("w1_hold", {if1.c_out, if1.sum}, last1);
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.c_in  = c;
        q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
        @(negedge clk);
        if8.start = 1'b0;
        if8.a     = 8'($urandom);
        if8.b     = 8'($urandom);
        if8.c_in  = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk("w8_busy_window", {if8.busy, if8.done}, 2'b10);
            @(negedge clk);
        end
        chk("w8_done_latency", {if8.busy, if8.done}, 2'b01);
        @(negedge clk);
        chk("w8_idle_after_done", {if8.busy, if8.done}, 2'b00);
    endtask

    initial begin
        int nd;
        rst_n = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.c_in = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.c_in = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.c_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_w8", {if8.busy, if8.done, if8.c_out, if8.sum}, 0);
        chk("reset_w4", {if4.busy, if4.done, if4.c_out, if4.sum}, 0);
        chk("reset_w1", {if1.busy, if1.done, if1.c_out, if1.sum}, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        op8(8'h55, 8'hAA, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'h7F, 8'h80, 1'b1);

        // Start held high; operand change mid-RUN must only affect the following operation.
        if8.start = 1'b1; if8.a = 8'h03; if8.b = 8'h04; if8.c_in = 1'b0;
        q8.push_back(9'h007);
        @(negedge clk);
        repeat (3) @(negedge clk);
        if8.a = 8'h10;
        q8.push_back(9'h014);
        repeat (5) @(negedge clk);
        chk("w8_held_first_done", {if8.busy, if8.done}, 2'b01);
        @(negedge clk);
        chk("w8_held_idle_gap", {if8.busy, if8.done}, 2'b00);
        @(negedge clk);
        chk("w8_held_second_accept", {if8.busy, if8.done}, 2'b10);
        if8.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("w8_held_second_done", {if8.busy, if8.done}, 2'b01);
        @(negedge clk);
        chk("w8_held_no_third", {if8.busy, if8.done}, 2'b00);

        // Abort mid-operation with asynchronous reset.
        if8.start = 1'b1; if8.a = 8'h55; if8.b = 8'h0F; if8.c_in = 1'b0;
        q8.push_back(9'h064);
        @(negedge clk);
        if8.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("w8_async_reset", {if8.busy, if8.done, if8.c_out, if8.sum}, 0);
        q8.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done) nd++;
        end
        chk("w8_no_done_after_abort", nd, 0);
        op8(8'h55, 8'hAA, 1'b0);

        if1.start = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.c_in = 1'b1;
        q1.push_back(2'b11);
        @(negedge clk);
        if1.start = 1'b0;
        chk("w1_busy", {if1.busy, if1.done}, 2'b10);
        @(negedge clk);
        chk("w1_done", {if1.busy, if1.done}, 2'b01);
        @(negedge clk);
        chk("w1_idle", {if1.busy, if1.done}, 2'b00);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    if4.start = 1'b1;
                    if4.a     = 4'(x);
                    if4.b     = 4'(y);
                    if4.c_in  = 1'(c);
                    q4.push_back(5'(x + y + c));
                    @(negedge clk);
                    if4.start = 1'b0;
                    repeat (4) @(negedge clk);
                    chk("w4_done_latency", if4.done, 1);
                    @(negedge clk);
                end
            end
        end

        repeat (3) @(negedge clk);
        chk("w8_queue_drained", q8.size(), 0);
        chk("w4_queue_drained", q4.size(), 0);
        chk("w1_queue_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
